// File: rtl/axis_lb_pkg.sv
// Shared constants and the tkeep legality rule for the AXI4-Stream loopback buffer.
package axis_lb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int STALL_OFF          = 0;
  localparam int BEAT_CNT_W         = 32;
  localparam int PKT_CNT_W          = 16;
  localparam int MAX_KEEP_W         = 128;

  // Legal keep: non-zero, ones packed from lane 0 upward, and fully set unless the beat ends a packet.
  function automatic logic is_legal_keep(input logic [MAX_KEEP_W-1:0] keep,
                                         input logic                  last,
                                         input int                    lanes);
    logic [MAX_KEEP_W-1:0] full_mask;
    full_mask = (lanes >= MAX_KEEP_W) ? '1 : ((MAX_KEEP_W'(1) << lanes) - MAX_KEEP_W'(1));
    if (keep == '0) return 1'b0;
    if ((keep & (keep + MAX_KEEP_W'(1))) != '0) return 1'b0;
    if (!last && (keep != full_mask)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/axis_loopback_buf_if.sv
// One AXI4-Stream link; master drives payload and valid, slave drives ready.
interface axis_loopback_buf_if #(
  parameter int DATA_WIDTH = axis_lb_pkg::DEFAULT_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_lb_fifo_mem.sv
// First-word-fall-through FIFO storage: array, wrapping pointers, fill level, full/empty flags.
module axis_lb_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_fill_level,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_fill;

  // NOTE: the array is deliberately not reset; pointers and fill level alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // NOTE: all state updates use <= so every register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign o_rd_data    = r_mem[r_rd_ptr];
  assign o_fill_level = r_fill;
  assign o_full       = (r_fill == (AW+1)'(DEPTH));
  assign o_empty      = (r_fill == '0);

endmodule

// File: rtl/axis_loopback_buf.sv
// AXI4-Stream loopback buffer between DMA MM2S and S2MM with throttle, counters and keep check.
// Define AXIS_LB_PKT_MODE_EN for store-and-forward; otherwise beats cut through as soon as stored.
module axis_loopback_buf
  import axis_lb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int DEPTH        = 16,
  parameter int STALL_PERIOD = STALL_OFF
) (
  input  logic                    axi_aclk,
  input  logic                    axi_reset,
  axis_loopback_buf_if.slave      s_axis,
  axis_loopback_buf_if.master     m_axis,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic [BEAT_CNT_W-1:0]   beat_count,
  output logic [PKT_CNT_W-1:0]    pkt_count,
  output logic                    keep_err
);
  localparam int KW   = DATA_WIDTH / 8;
  localparam int AW   = $clog2(DEPTH);
  localparam int EW   = DATA_WIDTH + KW + 1;
  localparam int SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_stall;
  logic            w_m_valid;
  logic [EW-1:0]   w_wr_entry;
  logic [EW-1:0]   w_rd_entry;
  logic [BEAT_CNT_W-1:0] r_beat_count;
  logic [PKT_CNT_W-1:0]  r_pkt_count;
  logic                  r_keep_err;

  assign w_wr_entry = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
  assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = w_rd_entry;

  // Ready looks only at stored state, so it never depends on either valid or downstream ready.
  assign s_axis.tready = !axi_reset && !w_full && !w_stall;
  assign w_push        = s_axis.tvalid && s_axis.tready;
  assign m_axis.tvalid = w_m_valid;
  assign w_pop         = w_m_valid && m_axis.tready;

  axis_lb_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (axi_aclk),
    .rst          (axi_reset),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_wr_data    (w_wr_entry),
    .o_rd_data    (w_rd_entry),
    .o_fill_level (fill_level),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  generate
    if (STALL_PERIOD == STALL_OFF) begin : g_no_stall
      assign w_stall = 1'b0;
    end else begin : g_stall
      logic [SC_W-1:0] r_stall_cnt;
      always_ff @(posedge axi_aclk) begin
        if (axi_reset || (r_stall_cnt == SC_W'(STALL_PERIOD - 1))) r_stall_cnt <= '0;
        else                                                    r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      assign w_stall = (r_stall_cnt == SC_W'(STALL_PERIOD - 1));
    end
  endgenerate

`ifdef AXIS_LB_PKT_MODE_EN
  // Count of complete packets held; a full FIFO with none releases beats so long packets cannot deadlock.
  logic [AW:0] r_pkt_stored;
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      r_pkt_stored <= '0;
    end else begin
      case ({w_push && s_axis.tlast, w_pop && m_axis.tlast})
        2'b10:   r_pkt_stored <= r_pkt_stored + 1'b1;
        2'b01:   r_pkt_stored <= r_pkt_stored - 1'b1;
        default: r_pkt_stored <= r_pkt_stored;
      endcase
    end
  end
  assign w_m_valid = !w_empty && ((r_pkt_stored != '0) || w_full);
`else
  assign w_m_valid = !w_empty;
`endif

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      r_beat_count <= '0;
      r_pkt_count  <= '0;
      r_keep_err   <= 1'b0;
    end else begin
      if (w_push) r_beat_count <= r_beat_count + 1'b1;
      if (w_pop && m_axis.tlast) r_pkt_count <= r_pkt_count + 1'b1;
      if (w_push && !is_legal_keep(MAX_KEEP_W'(s_axis.tkeep), s_axis.tlast, KW)) r_keep_err <= 1'b1;
    end
  end

  assign beat_count = r_beat_count;
  assign pkt_count  = r_pkt_count;
  assign keep_err   = r_keep_err;

endmodule

// File: tb/tb_axis_loopback_buf.sv
// Randomised bench for axis_loopback_buf against a queue-based model of the buffer's stream rules.
module tb_axis_loopback_buf;

  localparam int DW    = 32;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int FW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_loopback_buf_if #(.DATA_WIDTH(DW)) s_if ();
  axis_loopback_buf_if #(.DATA_WIDTH(DW)) m_if ();
  axis_loopback_buf_if #(.DATA_WIDTH(DW)) s2_if ();
  axis_loopback_buf_if #(.DATA_WIDTH(DW)) m2_if ();

  logic [FW-1:0] fill, fill2;
  logic [31:0]   beats, beats2;
  logic [15:0]   pkts, pkts2;
  logic          kerr, kerr2;

  axis_loopback_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STALL_PERIOD(0)) dut (
    .axi_aclk(clk), .axi_reset(rst), .s_axis(s_if), .m_axis(m_if),
    .fill_level(fill), .beat_count(beats), .pkt_count(pkts), .keep_err(kerr));

  axis_loopback_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STALL_PERIOD(4)) dut_st (
    .axi_aclk(clk), .axi_reset(rst), .s_axis(s2_if), .m_axis(m2_if),
    .fill_level(fill2), .beat_count(beats2), .pkt_count(pkts2), .keep_err(kerr2));

  beat_t       model_q[$];
  int unsigned m_beats, m_pkts;
  logic        m_kerr;
  int          n_pass, n_total, cyc;

  // Keep is legal when its ones are exactly the lowest N lanes, N>0, and N==KW unless last.
  function automatic logic ref_keep_ok(input logic [KW-1:0] keep, input logic last);
    int ones;
    ones = 0;
    for (int i = 0; i < KW; i++) ones += int'(keep[i]);
    if (ones == 0) return 1'b0;
    for (int i = 0; i < KW; i++) if (keep[i] != (i < ones)) return 1'b0;
    if (!last && ones != KW) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic ref_m_valid();
`ifdef AXIS_LB_PKT_MODE_EN
    int stored;
    stored = 0;
    foreach (model_q[i]) if (model_q[i].last) stored++;
    return (model_q.size() > 0) && (stored > 0 || model_q.size() == DEPTH);
`else
    return model_q.size() > 0;
`endif
  endfunction

  task automatic idle_inputs();
    s_if.tvalid = 1'b0;  s_if.tdata = '0;  s_if.tkeep = '0;  s_if.tlast = 1'b0;
    m_if.tready = 1'b0;
    s2_if.tvalid = 1'b0; s2_if.tdata = '0; s2_if.tkeep = '0; s2_if.tlast = 1'b0;
    m2_if.tready = 1'b1;
  endtask

  task automatic model_clear();
    model_q.delete();
    m_beats = 0;
    m_pkts  = 0;
    m_kerr  = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  // One clock of the main DUT: drive, compare against the model, then advance the model across the edge.
  task automatic cycle(input logic v, input beat_t b, input logic mr, output logic acc);
    logic exp_ready, exp_valid;
    s_if.tvalid = v; s_if.tdata = b.data; s_if.tkeep = b.keep; s_if.tlast = b.last;
    m_if.tready = mr;
    #1;
    exp_ready = model_q.size() < DEPTH;
    exp_valid = ref_m_valid();
    n_total++;
    if (s_if.tready !== exp_ready) $display("FAIL s_tready cyc=%0d got=%b exp=%b", cyc, s_if.tready, exp_ready);
    else n_pass++;
    n_total++;
    if (m_if.tvalid !== exp_valid) $display("FAIL m_tvalid cyc=%0d got=%b exp=%b", cyc, m_if.tvalid, exp_valid);
    else n_pass++;
    if (exp_valid) begin
      n_total++;
      if ({m_if.tlast, m_if.tkeep, m_if.tdata} !== model_q[0])
        $display("FAIL m_beat cyc=%0d got=%h exp=%h", cyc, {m_if.tlast, m_if.tkeep, m_if.tdata}, model_q[0]);
      else n_pass++;
    end
    n_total++;
    if (fill !== FW'(model_q.size())) $display("FAIL fill_level cyc=%0d got=%0d exp=%0d", cyc, fill, model_q.size());
    else n_pass++;
    n_total++;
    if (beats !== m_beats || pkts !== 16'(m_pkts) || kerr !== m_kerr)
      $display("FAIL status cyc=%0d got beats=%0d pkts=%0d kerr=%b exp beats=%0d pkts=%0d kerr=%b",
               cyc, beats, pkts, kerr, m_beats, m_pkts, m_kerr);
    else n_pass++;
    @(posedge clk);
    acc = v && exp_ready;
    if (exp_valid && mr) begin
      if (model_q[0].last) m_pkts++;
      void'(model_q.pop_front());
    end
    if (acc) begin
      model_q.push_back(b);
      m_beats++;
      if (!ref_keep_ok(b.keep, b.last)) m_kerr = 1'b1;
    end
    cyc++;
    #1;
  endtask

  task automatic send_beat(input beat_t b, input logic mr);
    logic acc;
    int   guard;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 4 * DEPTH) begin
      cycle(1'b1, b, mr, acc);
      guard++;
    end
    n_total++;
    if (!acc) $display("FAIL send_timeout cyc=%0d accepted=%b required=1", cyc, acc);
    else n_pass++;
  endtask

  task automatic drain();
    logic  acc;
    beat_t nb;
    int    guard;
    nb = '0;
    guard = 0;
    while (model_q.size() > 0 && guard < 4 * DEPTH) begin
      cycle(1'b0, nb, 1'b1, acc);
      guard++;
    end
    cycle(1'b0, nb, 1'b1, acc);
    n_total++;
    if (model_q.size() != 0) $display("FAIL drain_timeout cyc=%0d left=%0d required=0", cyc, model_q.size());
    else n_pass++;
  endtask

  function automatic beat_t mk(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.last = l;
    return b;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    n_total++;
    if (s_if.tready !== 1'b0 || s2_if.tready !== 1'b0)
      $display("FAIL reset_tready got=%b/%b exp=0/0", s_if.tready, s2_if.tready);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    #1;
    n_total++;
    if (fill !== '0 || m_if.tvalid !== 1'b0 || beats !== '0 || pkts !== '0 || kerr !== 1'b0)
      $display("FAIL reset_state got fill=%0d mv=%b beats=%0d pkts=%0d kerr=%b exp all zero",
               fill, m_if.tvalid, beats, pkts, kerr);
    else n_pass++;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 4; i++) send_beat(mk(DW'(i * 'h11), '1, i == 4), 1'b1);
    drain();
    n_total++;
    if (pkts !== 16'd1 || beats !== 32'd4) $display("FAIL basic_counts got pkts=%0d beats=%0d exp 1/4", pkts, beats);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    logic acc;
    int   sent;
    int   guard;
    sent = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, mk(32'hA000_0000 + DW'(sent), '1, sent == 19), 1'b0, acc);
      if (acc) sent++;
    end
    n_total++;
    if (fill !== FW'(DEPTH) || s_if.tready !== 1'b0)
      $display("FAIL full_hold got fill=%0d rdy=%b exp %0d/0", fill, s_if.tready, DEPTH);
    else n_pass++;
    guard = 0;
    while (sent < 20 && guard < 100) begin
      cycle(1'b1, mk(32'hA000_0000 + DW'(sent), '1, sent == 19), 1'b1, acc);
      if (acc) sent++;
      guard++;
    end
    drain();
  endtask

  task automatic test_random();
    beat_t cur;
    logic  cur_v, acc, mr;
    int    k;
    cur_v = 1'b0;
    cur = '0;
    for (int i = 0; i < 400; i++) begin
      if (!cur_v && $urandom_range(0, 3) != 0) begin
        cur.data = $urandom;
        cur.last = ($urandom_range(0, 4) == 0);
        k = $urandom_range(1, KW);
        cur.keep = cur.last ? KW'((1 << k) - 1) : '1;
        cur_v = 1'b1;
      end
      mr = ($urandom_range(0, 3) != 0);
      cycle(cur_v, cur, mr, acc);
      if (acc) cur_v = 1'b0;
    end
    send_beat(mk(32'hF1F1_F1F1, '1, 1'b1), 1'b1);
    drain();
  endtask

  task automatic test_keep_err();
    apply_reset();
    send_beat(mk(32'h0000_5555, 4'b0011, 1'b1), 1'b1);
    send_beat(mk(32'h0000_AAAA, 4'b0101, 1'b1), 1'b1);
    drain();
    n_total++;
    if (kerr !== 1'b1) $display("FAIL keep_err_sticky got=%b exp=1", kerr);
    else n_pass++;
    apply_reset();
    n_total++;
    if (kerr !== 1'b0) $display("FAIL keep_err_reset got=%b exp=0", kerr);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send_beat(mk(32'hC000_0000 + DW'(i), '1, 1'b0), 1'b0);
    n_total++;
    if (fill !== FW'(5)) $display("FAIL mid_fill got=%0d exp=5", fill);
    else n_pass++;
    apply_reset();
    n_total++;
    if (fill !== '0 || m_if.tvalid !== 1'b0 || beats !== '0 || pkts !== '0)
      $display("FAIL mid_reset got fill=%0d mv=%b beats=%0d pkts=%0d exp all zero", fill, m_if.tvalid, beats, pkts);
    else n_pass++;
    send_beat(mk(32'hD000_0001, '1, 1'b0), 1'b1);
    send_beat(mk(32'hD000_0002, 4'b0001, 1'b1), 1'b1);
    drain();
  endtask

  task automatic test_throttle();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      s2_if.tvalid = 1'b1; s2_if.tdata = DW'(i); s2_if.tkeep = '1; s2_if.tlast = 1'b1;
      m2_if.tready = 1'b1;
      #1;
      n_total++;
      if (s2_if.tready !== ((i % 4) != 3)) $display("FAIL throttle_rdy i=%0d got=%b exp=%b", i, s2_if.tready, (i % 4) != 3);
      else n_pass++;
      @(posedge clk); #1;
    end
    s2_if.tvalid = 1'b0;
    n_total++;
    if (beats2 !== 32'd9) $display("FAIL throttle_beats got=%0d exp=9", beats2);
    else n_pass++;
  endtask

`ifdef AXIS_LB_PKT_MODE_EN
  task automatic test_pkt_mode();
    apply_reset();
    for (int i = 0; i < 3; i++) send_beat(mk(32'hE000_0000 + DW'(i), '1, 1'b0), 1'b1);
    n_total++;
    if (m_if.tvalid !== 1'b0) $display("FAIL pkt_hold got=%b exp=0", m_if.tvalid);
    else n_pass++;
    send_beat(mk(32'hE000_0003, '1, 1'b1), 1'b1);
    drain();
    for (int i = 0; i < 20; i++) send_beat(mk(32'hB000_0000 + DW'(i), '1, i == 19), 1'b1);
    drain();
    n_total++;
    if (pkts !== 16'd2) $display("FAIL pkt_long got pkts=%0d exp=2", pkts);
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;
    model_clear();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_full_wrap();
    test_random();
    test_keep_err();
    test_reset_mid();
    test_throttle();
`ifdef AXIS_LB_PKT_MODE_EN
    test_pkt_mode();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d run did not complete", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
